// File: rtl/freq_ascii_formatter.sv
// Binary peak frequency to 5 ASCII digits via iterative double-dabble, plus the NFFT text field.
// Outputs are held registers that update together on a completed conversion.
`timescale 1ns / 1ps
module freq_ascii_formatter #(
  parameter int unsigned FREQ_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FREQ_W-1:0] freq_hz,
  input  logic              freq_valid,
  input  logic [1:0]        nfft_sel,
  output logic              busy,
  output logic              done,
  output logic [7:0]        d1,
  output logic [7:0]        d2,
  output logic [7:0]        d3,
  output logic [7:0]        d4,
  output logic [7:0]        d5,
  output logic [31:0]       nfft_chars
);

  localparam int unsigned IterW = (FREQ_W > 1) ? $clog2(FREQ_W) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StFormat} state_e;

  state_e             state_q, state_d;
  logic [IterW-1:0]   iter_q, iter_d;
  logic [FREQ_W-1:0]  bin_q, bin_d;
  logic [19:0]        bcd_q, bcd_d, bcd_adj;
  logic [1:0]         sel_q, sel_d;
  logic [FREQ_W-1:0]  pend_val_q, pend_val_d;
  logic [1:0]         pend_sel_q, pend_sel_d;
  logic               pend_vld_q, pend_vld_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [4:0][7:0]    dig_q, dig_d;
  logic [31:0]        nfft_q, nfft_d;

  logic               do_load;
  logic [FREQ_W-1:0]  load_val;
  logic [1:0]         load_sel;
  logic               blank;

  function automatic logic [FREQ_W-1:0] sat(input logic [FREQ_W-1:0] v);
    if (32'(v) > 32'd99999) return FREQ_W'(99999);
    return v;
  endfunction

  // Add-3 correction on every nibble that would overflow past 9 after the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    sel_d      = sel_q;
    pend_val_d = pend_val_q;
    pend_sel_d = pend_sel_q;
    pend_vld_d = pend_vld_q;
    done_d     = 1'b0;
    dig_d      = dig_q;
    nfft_d     = nfft_q;
    do_load    = 1'b0;
    load_val   = freq_hz;
    load_sel   = nfft_sel;
    blank      = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (freq_valid) do_load = 1'b1;
      end
      StShift: begin
        {bcd_d, bin_d} = {bcd_adj[18:0], bin_q, 1'b0};
        iter_d = iter_q + 1'b1;
        if (iter_q == IterW'(FREQ_W - 1)) state_d = StFormat;
        if (freq_valid) begin
          pend_val_d = freq_hz;
          pend_sel_d = nfft_sel;
          pend_vld_d = 1'b1;
        end
      end
      StFormat: begin
        done_d = 1'b1;
        // Blank leading zeros on the upper four digits; the units digit is always shown.
        for (int i = 4; i >= 1; i--) begin
          if (blank && (bcd_q[4*i +: 4] == 4'd0)) begin
            dig_d[i] = 8'h20;
          end else begin
            blank    = 1'b0;
            dig_d[i] = {4'h3, bcd_q[4*i +: 4]};
          end
        end
        dig_d[0] = {4'h3, bcd_q[3:0]};
        case (sel_q)
          2'b00:   nfft_d = " 256";
          2'b01:   nfft_d = " 512";
          2'b10:   nfft_d = "1024";
          default: nfft_d = "2048";
        endcase
        if (freq_valid) begin
          do_load    = 1'b1;
          pend_vld_d = 1'b0;
        end else if (pend_vld_q) begin
          do_load    = 1'b1;
          load_val   = pend_val_q;
          load_sel   = pend_sel_q;
          pend_vld_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_load) begin
      bin_d   = sat(load_val);
      sel_d   = load_sel;
      bcd_d   = '0;
      iter_d  = '0;
      state_d = StShift;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      iter_q     <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      sel_q      <= '0;
      pend_val_q <= '0;
      pend_sel_q <= '0;
      pend_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dig_q      <= {8'h20, 8'h20, 8'h20, 8'h20, 8'h30};
      nfft_q     <= 32'h2020_2020;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      sel_q      <= sel_d;
      pend_val_q <= pend_val_d;
      pend_sel_q <= pend_sel_d;
      pend_vld_q <= pend_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dig_q      <= dig_d;
      nfft_q     <= nfft_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign d1         = dig_q[4];
  assign d2         = dig_q[3];
  assign d3         = dig_q[2];
  assign d4         = dig_q[1];
  assign d5         = dig_q[0];
  assign nfft_chars = nfft_q;

endmodule
